// File: rtl/synapse_pkg.sv
// rtl/synapse_pkg.sv - default parameters and width helpers shared by synapse_array and synapse_channel
package synapse_pkg;

   localparam int C_CH       = 4;
   localparam int C_WIDTH    = 8;
   localparam int C_SHIFT    = 8;
   localparam int C_DECAY    = 4;
   localparam int C_PRESCALE = 16;

   function automatic int trace_width(input int width, input int shift);
      return width + shift;
   endfunction

   // Wide enough that every channel at all-ones cannot overflow the sum.
   function automatic int sum_width(input int width, input int shift, input int ch);
      return width + shift + $clog2(ch);
   endfunction

endpackage

// File: rtl/synapse_channel.sv
// rtl/synapse_channel.sv - one synapse: event synchroniser, edge detect, decaying trace register
// SYNAPSE_ARRAY_ACCUM_EN selects saturating accumulate on events instead of reload.
module synapse_channel
   import synapse_pkg::*;
#(
   parameter int P_WIDTH = C_WIDTH,
   parameter int P_SHIFT = C_SHIFT,
   parameter int P_DECAY = C_DECAY
) (
   input  logic                                      i_clk,
   input  logic                                      i_rst,
   input  logic                                      i_event,
   input  logic [P_WIDTH-1:0]                        i_weight,
   input  logic                                      i_tick,
   output logic                                      o_sync,
   output logic [trace_width(P_WIDTH, P_SHIFT)-1:0]  o_trace
);

   localparam int TW = trace_width(P_WIDTH, P_SHIFT);

   logic          r_meta;
   logic          r_sync;
   logic          r_prev;
   logic          r_pulse;
   logic [1:0]    r_fill;
   logic [TW-1:0] r_trace;

   logic [TW-1:0] w_load;
   logic [TW-1:0] w_step;
   logic [TW-1:0] w_decayed;
   logic [TW-1:0] w_event_val;

   assign w_load    = TW'(i_weight) << P_SHIFT;
   assign w_step    = r_trace >> P_DECAY;
   assign w_decayed = r_trace - ((w_step == '0) ? TW'(1) : w_step);

`ifdef SYNAPSE_ARRAY_ACCUM_EN
   logic [TW:0] w_acc;
   assign w_acc       = {1'b0, r_trace} + {1'b0, w_load};
   assign w_event_val = w_acc[TW] ? '1 : w_acc[TW-1:0];
`else
   assign w_event_val = w_load;
`endif

   // r_prev reads as high until the synchroniser has refilled after reset,
   // so a level already present at reset release never looks like an edge.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_meta  <= 1'b0;
         r_sync  <= 1'b0;
         r_prev  <= 1'b1;
         r_fill  <= 2'b00;
         r_pulse <= 1'b0;
         r_trace <= '0;
      end else begin
         r_meta  <= i_event;
         r_sync  <= r_meta;
         r_fill  <= {r_fill[0], 1'b1};
         r_prev  <= r_fill[1] ? r_sync : 1'b1;
         r_pulse <= r_sync & ~r_prev;
         if (r_pulse) begin
            r_trace <= w_event_val;
         end else if (i_tick && (r_trace != '0)) begin
            r_trace <= w_decayed;
         end
      end
   end

   assign o_sync  = r_pulse;
   assign o_trace = r_trace;

endmodule

// File: rtl/synapse_array.sv
// rtl/synapse_array.sv - array of decaying synapse traces with shared leak prescaler and registered trace sum
// SYNAPSE_ARRAY_ACCUM_EN (in synapse_channel) selects accumulate-on-event.
module synapse_array
   import synapse_pkg::*;
#(
   parameter int P_CH       = C_CH,
   parameter int P_WIDTH    = C_WIDTH,
   parameter int P_SHIFT    = C_SHIFT,
   parameter int P_DECAY    = C_DECAY,
   parameter int P_PRESCALE = C_PRESCALE
) (
   input  logic                                             i_clk,
   input  logic                                             i_rst,
   input  logic [P_CH-1:0]                                  i_event,
   input  logic [P_CH*P_WIDTH-1:0]                          i_weight,
   input  logic                                             i_leak_en,
   output logic [P_CH-1:0]                                  o_sync,
   output logic [P_CH*trace_width(P_WIDTH, P_SHIFT)-1:0]    o_do,
   output logic [P_CH-1:0]                                  o_active,
   output logic [sum_width(P_WIDTH, P_SHIFT, P_CH)-1:0]     o_sum
);

   localparam int TW = trace_width(P_WIDTH, P_SHIFT);
   localparam int SW = sum_width(P_WIDTH, P_SHIFT, P_CH);
   localparam int PW = (P_PRESCALE > 1) ? $clog2(P_PRESCALE) : 1;

   logic [PW-1:0] r_pre;
   logic [SW-1:0] r_sum;
   logic          w_tick;
   logic [SW-1:0] w_sum;
   logic [TW-1:0] w_trace [P_CH];

   assign w_tick = i_leak_en && (r_pre == PW'(P_PRESCALE - 1));

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_pre <= '0;
      end else if (i_leak_en) begin
         r_pre <= w_tick ? '0 : r_pre + 1'b1;
      end
   end

   for (genvar c = 0; c < P_CH; c++) begin : g_ch
      synapse_channel #(
         .P_WIDTH (P_WIDTH),
         .P_SHIFT (P_SHIFT),
         .P_DECAY (P_DECAY)
      ) u_channel (
         .i_clk    (i_clk),
         .i_rst    (i_rst),
         .i_event  (i_event[c]),
         .i_weight (i_weight[c*P_WIDTH +: P_WIDTH]),
         .i_tick   (w_tick),
         .o_sync   (o_sync[c]),
         .o_trace  (w_trace[c])
      );
      assign o_do[c*TW +: TW] = w_trace[c];
      assign o_active[c]      = |w_trace[c];
   end

   always_comb begin
      w_sum = '0;
      for (int c = 0; c < P_CH; c++) begin
         w_sum = w_sum + SW'(w_trace[c]);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sum <= '0;
      end else begin
         r_sum <= w_sum;
      end
   end

   assign o_sum = r_sum;

endmodule

// File: tb/tb_synapse_array.sv
// tb/tb_synapse_array.sv - randomized self-checking bench for synapse_array against a behavioural model
module tb_synapse_array;

   localparam int CH = 4;
   localparam int WD = 8;
   localparam int SH = 8;
   localparam int DC = 4;
   localparam int PS = 16;
   localparam int TW = WD + SH;
   localparam int SW = TW + $clog2(CH);

   logic              clk = 1'b0;
   logic              rst;
   logic [CH-1:0]     ev;
   logic [CH*WD-1:0]  wt;
   logic              leak;
   logic [CH-1:0]     o_sync;
   logic [CH*TW-1:0]  o_do;
   logic [CH-1:0]     o_active;
   logic [SW-1:0]     o_sum;

   always #5 clk = ~clk;

   synapse_array #(
      .P_CH       (CH),
      .P_WIDTH    (WD),
      .P_SHIFT    (SH),
      .P_DECAY    (DC),
      .P_PRESCALE (PS)
   ) dut (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_event   (ev),
      .i_weight  (wt),
      .i_leak_en (leak),
      .o_sync    (o_sync),
      .o_do      (o_do),
      .o_active  (o_active),
      .o_sum     (o_sum)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference model: event sample history since reset (index 0 stands for
   // the level at reset, treated as already high), enabled-cycle count for
   // the leak, and plain integer traces.
   bit          hist [CH][$];
   int unsigned m_trace [CH];
   bit          m_sync [CH];
   int unsigned m_sum;
   int          m_en_count;

   task automatic model_edge();
      if (rst) begin
         for (int c = 0; c < CH; c++) begin
            hist[c].delete();
            hist[c].push_back(1'b1);
            m_trace[c] = 0;
            m_sync[c]  = 1'b0;
         end
         m_sum      = 0;
         m_en_count = 0;
      end else begin
         int unsigned old_sum;
         bit          tick;
         old_sum = 0;
         for (int c = 0; c < CH; c++) old_sum += m_trace[c];
         tick = 1'b0;
         if (leak) begin
            m_en_count++;
            tick = ((m_en_count % PS) == 0);
         end
         for (int c = 0; c < CH; c++) begin
            int unsigned w;
            int          n;
            w = int'(wt[c*WD +: WD]) * (1 << SH);
            if (m_sync[c]) begin
`ifdef SYNAPSE_ARRAY_ACCUM_EN
               m_trace[c] = (m_trace[c] + w > (1 << TW) - 1) ? (1 << TW) - 1 : m_trace[c] + w;
`else
               m_trace[c] = w;
`endif
            end else if (tick && m_trace[c] != 0) begin
               m_trace[c] -= ((m_trace[c] / (1 << DC)) == 0) ? 1 : m_trace[c] / (1 << DC);
            end
            hist[c].push_back(ev[c]);
            n = hist[c].size() - 1;
            m_sync[c] = (n >= 3) && hist[c][n-2] && !hist[c][n-3];
         end
         m_sum = old_sum;
      end
   endtask

   task automatic compare_all();
      for (int c = 0; c < CH; c++) begin
         check($sformatf("sync%0d", c), o_sync[c], m_sync[c]);
         check($sformatf("do%0d", c), o_do[c*TW +: TW], m_trace[c]);
         check($sformatf("active%0d", c), o_active[c], m_trace[c] != 0);
      end
      check("sum", o_sum, m_sum);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      model_edge();
      compare_all();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
      repeat (3) step();
   endtask

   initial begin
      logic [TW-1:0] prev_v;
      rst  = 1'b1;
      ev   = '0;
      wt   = '0;
      leak = 1'b0;
      step();
      step();
      check("rst_do", o_do, 0);
      check("rst_sum", o_sum, 0);
      check("rst_sync", o_sync, 0);
      rst = 1'b0;
      repeat (3) step();

      // Single event, weight 0x80, pulse on third edge; held high -> one pulse.
      wt[7:0] = 8'h80;
      ev[0]   = 1'b1;
      step(); check("e_edge1", o_sync[0], 0);
      step(); check("e_edge2", o_sync[0], 0);
      step(); check("e_edge3", o_sync[0], 1);
      step(); check("e_do", o_do[15:0], 16'h8000); check("e_active", o_active[0], 1); check("e_once", o_sync[0], 0);
      repeat (4) step();
      ev[0] = 1'b0;
      step();

      // Decay from 0x8000, ticks 16 cycles apart.
      leak = 1'b1;
      repeat (15) step();
      check("d_pre1", o_do[15:0], 16'h8000);
      step();
      check("d_tick1", o_do[15:0], 16'h7800);
      repeat (15) step();
      check("d_pre2", o_do[15:0], 16'h7800);
      step();
      check("d_tick2", o_do[15:0], 16'h7080);

      // Small trace decays by one per tick to zero and stays there.
      leak = 1'b0;
      do_reset();
      wt[7:0] = 8'h01;
      ev[0]   = 1'b1;
      repeat (4) step();
      ev[0] = 1'b0;
      leak  = 1'b1;
      for (int i = 0; i < 4000 && o_do[15:0] != 0; i++) begin
         prev_v = o_do[15:0];
         step();
         if (o_do[15:0] != prev_v && prev_v < 16) check("z_dec1", o_do[15:0], prev_v - 1);
      end
      check("z_reached", o_do[15:0], 0);
      check("z_inactive", o_active[0], 0);
      repeat (48) step();
      check("z_stays", o_do[15:0], 0);

      // Event coincident with a tick: event wins, no decay.
      leak = 1'b0;
      do_reset();
      wt[7:0] = 8'h40;
      ev[0]   = 1'b1;
      repeat (4) step();
      ev[0] = 1'b0;
      repeat (2) step();
      check("c_base", o_do[15:0], 16'h4000);
      leak = 1'b1;
      repeat (12) step();
      wt[7:0] = 8'h10;
      ev[0]   = 1'b1;
      repeat (4) step();
`ifdef SYNAPSE_ARRAY_ACCUM_EN
      check("c_result", o_do[15:0], 16'h5000);
`else
      check("c_result", o_do[15:0], 16'h1000);
`endif
      ev[0] = 1'b0;
      leak  = 1'b0;

`ifdef SYNAPSE_ARRAY_ACCUM_EN
      do_reset();
      wt[7:0] = 8'hF0;
      ev[0]   = 1'b1;
      repeat (4) step();
      ev[0] = 1'b0;
      repeat (2) step();
      wt[7:0] = 8'h20;
      ev[0]   = 1'b1;
      repeat (4) step();
      check("s_sat", o_do[15:0], 16'hFFFF);
      ev[0] = 1'b0;
`endif

      // All channels at once, sum one cycle after traces.
      do_reset();
      wt = {CH{8'hFF}};
      ev = '1;
      repeat (4) step();
      check("a_do", o_do, {CH{16'hFF00}});
      check("a_sum_lag", o_sum, 0);
      step();
      check("a_sum", o_sum, 18'h3FC00);
      ev = '0;

      // Reset mid-decay with an event inside the synchroniser.
      leak = 1'b1;
      repeat (20) step();
      ev[1] = 1'b1;
      step();
      rst = 1'b1;
      step();
      check("r_do", o_do, 0);
      check("r_sync", o_sync, 0);
      check("r_active", o_active, 0);
      check("r_sum", o_sum, 0);
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         check("r_nopulse", o_sync[1], 0);
      end
      ev[1] = 1'b0;

      // Randomized traffic.
      for (int cyc = 0; cyc < 2500; cyc++) begin
         rst = ($urandom_range(299) == 0);
         for (int c = 0; c < CH; c++) begin
            if ($urandom_range(5) == 0) ev[c] = ~ev[c];
            if ($urandom_range(19) == 0) wt[c*WD +: WD] = 8'($urandom);
         end
         if ($urandom_range(49) == 0) leak = ~leak;
         step();
      end
      rst = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/synapse_array.md
SYNAPSE_ARRAY -- requirements
Module: synapse_array

Interface
REQ-001 SHALL have parameter P_CH, default 4: number of independent synapse channels.
REQ-002 SHALL have parameter P_WIDTH, default 8: weight width per channel.
REQ-003 SHALL have parameter P_SHIFT, default 8: left shift applied to weight; trace width TW = P_WIDTH+P_SHIFT.
REQ-004 SHALL have parameter P_DECAY, default 4: decay shift per leak tick.
REQ-005 SHALL have parameter P_PRESCALE, default 16: clock cycles per leak tick (>=2).
REQ-006 SHALL have port i_clk, input, 1: single clock; all logic on its rising edge.
REQ-007 SHALL have port i_rst, input, 1: synchronous, active-high reset.
REQ-008 SHALL have port i_event, input, P_CH: asynchronous event lines, one per channel; rising edge = event.
REQ-009 SHALL have port i_weight, input, P_CH*P_WIDTH: per-channel weight, channel c at bits [c*P_WIDTH +: P_WIDTH], unsigned.
REQ-010 SHALL have port i_leak_en, input, 1: enables the leak prescaler.
REQ-011 SHALL have port o_sync, output, P_CH: one-cycle synchronised event pulse per channel.
REQ-012 SHALL have port o_do, output, P_CH*TW: per-channel trace, channel c at [c*TW +: TW].
REQ-013 SHALL have port o_active, output, P_CH: channel trace non-zero.
REQ-014 SHALL have port o_sum, output, TW+$clog2(P_CH): registered sum of all traces.

Function
REQ-015 SHALL pass each i_event bit through a two-flop synchroniser plus a previous-value register; o_sync[c] is high for exactly one cycle per synchronised rising edge.
REQ-016 SHALL assert o_sync[c] on the third rising clock edge after i_event[c] is first sampled high; an event held high longer produces one pulse only.
REQ-017 SHALL keep a prescaler counting 0..P_PRESCALE-1 while i_leak_en=1, holding its value while i_leak_en=0; leak tick is a one-cycle internal strobe when count=P_PRESCALE-1 and i_leak_en=1, and the count wraps to 0 on that cycle.
REQ-018 SHALL, on a cycle with o_sync[c]=1, load trace[c] <= {i_weight[c], P_SHIFT zeros} (reload mode); o_do visible one cycle after o_sync.
REQ-019 SHALL, on a leak tick with no o_sync[c] and trace[c]!=0, set trace[c] <= trace[c] - (trace[c]>>P_DECAY), or trace[c]-1 when (trace[c]>>P_DECAY)=0, so the trace always reaches 0.
REQ-020 SHALL give event priority over leak: simultaneous o_sync[c] and tick applies only the event update, no decay that cycle.
REQ-021 SHALL hold trace[c] unchanged when neither event nor tick occurs, and leave a zero trace at zero on a tick.
REQ-022 SHALL drive o_active[c] combinationally as (trace[c]!=0).
REQ-023 SHALL update o_sum one cycle after o_do changes; width guarantees no overflow.
REQ-024 SHALL treat channels independently; simultaneous events on all channels are all applied in the same cycle.
REQ-025 SHALL treat weight 0 as a valid event that loads trace 0 (reload mode).

Reset
REQ-026 SHALL, while i_rst=1 at a clock edge, clear synchroniser flops, prescaler, all traces and o_sum; o_sync=0, o_do=0, o_active=0, o_sum=0 after that edge.
REQ-027 SHALL discard any event in flight in the synchroniser at reset; an i_event held high across reset release produces no pulse.

Configuration
REQ-028 SHALL use macro SYNAPSE_ARRAY_ACCUM_EN: when defined, event does saturating add trace[c] <= min(trace[c] + {i_weight[c], P_SHIFT zeros}, all-ones TW); when undefined, reload per REQ-018. Event-over-leak priority is unchanged in both.

Structure
REQ-029 SHALL place trace-width and sum-width helper functions and the default parameter constants in shared package synapse_pkg.
REQ-030 SHALL instantiate one sub-module synapse_channel per channel (synchroniser, edge detect, trace register, decay/accumulate arithmetic); prescaler and summation reside in synapse_array.

Verification
REQ-031 SHALL check: i_event[0] rises, weight 0x80 -> o_sync[0] pulse on 3rd edge, o_do[0]=0x8000 next cycle, o_active[0]=1.
REQ-032 SHALL check: trace 0x8000, i_leak_en=1, P_PRESCALE=16 -> 0x7800 after first tick, 0x7080 after second, ticks exactly 16 cycles apart.
REQ-033 SHALL check: trace 0x000F decaying -> decrements by 1 per tick to 0, o_active falls, remains 0 on later ticks.
REQ-034 SHALL check: event coincident with tick on trace 0x4000, weight 0x10 -> 0x1000 (reload) or 0x5000 (ACCUM_EN), no decay.
REQ-035 SHALL check: ACCUM_EN, trace 0xF000, weight 0x20 -> 0xFFFF saturated; all 4 channels weight 0xFF together -> o_sum=0x3FC00 one cycle after o_do.
REQ-036 SHALL check: i_rst asserted mid-decay with event in synchroniser -> all outputs 0 next edge, no o_sync pulse after release.
